// File: rtl/ddr3_cmd_sequencer.sv
// ddr3_cmd_sequencer
// Closed-page command sequencer for one x8 DDR3 rank. Each accepted request
// becomes one ACT -> RD/WR -> PRE sequence. Periodic REFRESH is issued from
// IDLE whenever the refresh interval has elapsed. DQ/DQS/DM are handled by the
// datapath, which aligns to the RD_ISSUE/WR_ISSUE strobes.
//
// Ports
//   CPU_CLK, RESET_N        clock, synchronous active-low reset
//   ADDR_VALID, CMD, ADDR   request channel (CMD 1 = write, 0 = read)
//   REQ_RDY                 request accepted when ADDR_VALID & REQ_RDY
//   CS_N/RAS_N/CAS_N/WE_N   DRAM command pins
//   BA, MADDR               DRAM bank and address bus
//   RD_ISSUE, WR_ISSUE      one-cycle strobes in the RD/WR command cycle
//   BUSY                    high whenever the sequencer is not IDLE
module ddr3_cmd_sequencer #(
    parameter int T_INIT   = 500,
    parameter int T_RCD    = 5,
    parameter int T_RAS    = 15,
    parameter int T_RD2PRE = 4,
    parameter int T_WR2PRE = 14,
    parameter int T_RP     = 5,
    parameter int T_RFC    = 44,
    parameter int T_REFI   = 3120
) (
    input  logic        CPU_CLK,
    input  logic        RESET_N,
    input  logic        ADDR_VALID,
    input  logic        CMD,
    input  logic [31:0] ADDR,
    output logic        REQ_RDY,
    output logic        CS_N,
    output logic        RAS_N,
    output logic        CAS_N,
    output logic        WE_N,
    output logic [2:0]  BA,
    output logic [14:0] MADDR,
    output logic        RD_ISSUE,
    output logic        WR_ISSUE,
    output logic        BUSY
);

    localparam int TW = 8;   // timing counter width
    localparam int LW = 16;  // init / refresh-interval counter width

    localparam logic [TW-1:0] RCD_LD    = TW'(T_RCD - 1);
    localparam logic [TW-1:0] RAS_LD    = TW'(T_RAS - 1);
    localparam logic [TW-1:0] RD2PRE_LD = TW'(T_RD2PRE - 1);
    localparam logic [TW-1:0] WR2PRE_LD = TW'(T_WR2PRE - 1);
    localparam logic [TW-1:0] RP_LD     = TW'(T_RP - 1);
    localparam logic [TW-1:0] RFC_LD    = TW'(T_RFC - 1);
    localparam logic [LW-1:0] INIT_LAST = LW'(T_INIT - 1);
    localparam logic [LW-1:0] REFI_LD   = LW'(T_REFI - 1);

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] C_DESEL = 4'b1111;
    localparam logic [3:0] C_NOP   = 4'b0111;
    localparam logic [3:0] C_ACT   = 4'b0011;
    localparam logic [3:0] C_RD    = 4'b0101;
    localparam logic [3:0] C_WR    = 4'b0100;
    localparam logic [3:0] C_PRE   = 4'b0010;
    localparam logic [3:0] C_REF   = 4'b0001;

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_ACT, S_WAIT_RCD, S_RDWR,
        S_WAIT_PRE, S_PRE, S_WAIT_RP, S_REF, S_WAIT_RFC
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   init_cnt_q, init_cnt_d;
    logic [LW-1:0]   refi_q, refi_d;
    logic            ref_pend_q, ref_pend_d;
    logic [TW-1:0]   tmr_q, tmr_d;      // shared tRCD / post / tRP / tRFC timer
    logic [TW-1:0]   ras_q, ras_d;
    logic            cmd_wr_q, cmd_wr_d;
    logic [2:0]      ba_q, ba_d;
    logic [14:0]     row_q, row_d;
    logic [9:0]      col_q, col_d;
    logic [3:0]      pins_q, pins_d;
    logic [14:0]     maddr_q, maddr_d;
    logic            rd_q, rd_d, wr_q, wr_d;
    logic            req_rdy_q, req_rdy_d;
    logic            busy_q, busy_d;

    logic            refi_expire;
    logic [TW-1:0]   post_ld;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^{ADDR[31:28], ADDR[2:0]};

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
        return (v == '0) ? v : v - TW'(1);
    endfunction

    // A timer value of 1 (or 0) means the timer reaches 0 on this edge, so the
    // following state is entered exactly T cycles after the load cycle.
    function automatic logic done(input logic [TW-1:0] v);
        return v <= TW'(1);
    endfunction

    assign refi_expire = (state_q != S_INIT) && (refi_q == '0);
    assign post_ld     = cmd_wr_q ? WR2PRE_LD : RD2PRE_LD;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        tmr_d      = sat_dec(tmr_q);
        ras_d      = sat_dec(ras_q);
        cmd_wr_d   = cmd_wr_q;
        ba_d       = ba_q;
        row_d      = row_q;
        col_d      = col_q;
        refi_d     = refi_q;
        if (state_q != S_INIT) begin
            refi_d = refi_expire ? REFI_LD : refi_q - LW'(1);
        end
        // A new expiry wins over the clear from a same-cycle REF; a second
        // expiry while already pending simply leaves the flag set.
        ref_pend_d = refi_expire | (ref_pend_q & (state_q != S_REF));

        case (state_q)
            S_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d = S_IDLE;
                    refi_d  = REFI_LD;
                end else begin
                    init_cnt_d = init_cnt_q + LW'(1);
                end
            end
            S_IDLE: begin
                if (ref_pend_q) begin
                    state_d = S_REF;
                end else if (ADDR_VALID) begin
                    state_d  = S_ACT;
                    cmd_wr_d = CMD;
                    ba_d     = ADDR[12:10];
                    row_d    = ADDR[27:13];
                    col_d    = {ADDR[9:3], 3'b000};
                end
            end
            S_ACT: begin
                tmr_d   = RCD_LD;
                ras_d   = RAS_LD;
                state_d = (RCD_LD == '0) ? S_RDWR : S_WAIT_RCD;
            end
            S_WAIT_RCD: if (done(tmr_q)) state_d = S_RDWR;
            S_RDWR: begin
                tmr_d   = post_ld;
                state_d = ((post_ld == '0) && done(ras_q)) ? S_PRE : S_WAIT_PRE;
            end
            S_WAIT_PRE: if (done(tmr_q) && done(ras_q)) state_d = S_PRE;
            S_PRE: begin
                tmr_d   = RP_LD;
                state_d = (RP_LD == '0) ? S_IDLE : S_WAIT_RP;
            end
            S_WAIT_RP: if (done(tmr_q)) state_d = S_IDLE;
            S_REF: begin
                tmr_d   = RFC_LD;
                state_d = (RFC_LD == '0) ? S_IDLE : S_WAIT_RFC;
            end
            S_WAIT_RFC: if (done(tmr_q)) state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase

        // Outputs are decoded from the next state so the pins line up with
        // the registered state.
        pins_d  = (state_d == S_INIT) ? C_DESEL : C_NOP;
        maddr_d = '0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        case (state_d)
            S_ACT: begin
                pins_d  = C_ACT;
                maddr_d = row_d;
            end
            S_RDWR: begin
                pins_d  = cmd_wr_d ? C_WR : C_RD;
                maddr_d = {5'b0, col_d};
                rd_d    = ~cmd_wr_d;
                wr_d    = cmd_wr_d;
            end
            S_PRE:   pins_d = C_PRE;
            S_REF:   pins_d = C_REF;
            default: ;
        endcase
        req_rdy_d = (state_d == S_IDLE) && !ref_pend_d;
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge CPU_CLK) begin
        if (!RESET_N) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            refi_q     <= '0;
            ref_pend_q <= 1'b0;
            tmr_q      <= '0;
            ras_q      <= '0;
            cmd_wr_q   <= 1'b0;
            ba_q       <= '0;
            row_q      <= '0;
            col_q      <= '0;
            pins_q     <= C_DESEL;
            maddr_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            req_rdy_q  <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            refi_q     <= refi_d;
            ref_pend_q <= ref_pend_d;
            tmr_q      <= tmr_d;
            ras_q      <= ras_d;
            cmd_wr_q   <= cmd_wr_d;
            ba_q       <= ba_d;
            row_q      <= row_d;
            col_q      <= col_d;
            pins_q     <= pins_d;
            maddr_q    <= maddr_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            req_rdy_q  <= req_rdy_d;
            busy_q     <= busy_d;
        end
    end

    assign {CS_N, RAS_N, CAS_N, WE_N} = pins_q;
    assign BA       = ba_q;
    assign MADDR    = maddr_q;
    assign RD_ISSUE = rd_q;
    assign WR_ISSUE = wr_q;
    assign REQ_RDY  = req_rdy_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_ddr3_cmd_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench: the stimulus process runs a timing-rule model (absolute
// cycle arithmetic) and queues the expected commands and per-cycle status; a
// separate monitor compares them against the DUT pins.
module tb_ddr3_cmd_sequencer;

    localparam int T_INIT   = 500;
    localparam int T_RCD    = 5;
    localparam int T_RAS    = 15;
    localparam int T_RD2PRE = 4;
    localparam int T_WR2PRE = 14;
    localparam int T_RP     = 5;
    localparam int T_RFC    = 44;
    localparam int T_REFI   = 3120;

    logic        CPU_CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        ADDR_VALID = 1'b0;
    logic        CMD = 1'b0;
    logic [31:0] ADDR = '0;
    logic        REQ_RDY, CS_N, RAS_N, CAS_N, WE_N;
    logic [2:0]  BA;
    logic [14:0] MADDR;
    logic        RD_ISSUE, WR_ISSUE, BUSY;

    always #5 CPU_CLK = ~CPU_CLK;

    ddr3_cmd_sequencer #(
        .T_INIT(T_INIT), .T_RCD(T_RCD), .T_RAS(T_RAS), .T_RD2PRE(T_RD2PRE),
        .T_WR2PRE(T_WR2PRE), .T_RP(T_RP), .T_RFC(T_RFC), .T_REFI(T_REFI)
    ) dut (
        .CPU_CLK(CPU_CLK), .RESET_N(RESET_N), .ADDR_VALID(ADDR_VALID),
        .CMD(CMD), .ADDR(ADDR), .REQ_RDY(REQ_RDY), .CS_N(CS_N),
        .RAS_N(RAS_N), .CAS_N(CAS_N), .WE_N(WE_N), .BA(BA), .MADDR(MADDR),
        .RD_ISSUE(RD_ISSUE), .WR_ISSUE(WR_ISSUE), .BUSY(BUSY)
    );

    typedef struct {
        int         cyc;
        logic [3:0] code;
        logic [2:0] ba;
        logic       chk_ba;
        logic [14:0] maddr;
        logic       rd;
        logic       wr;
    } cmd_exp_t;

    typedef struct {
        int         cyc;
        logic       rdy;
        logic       busy;
        logic [3:0] quiet;
    } stat_exp_t;

    cmd_exp_t  cmd_q[$];
    stat_exp_t stat_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int mon_cyc = 0;

    // Cycle index: 0 is the cycle following the last reset edge.
    int   cyc = 0;
    logic rst_seen = 1'b1;
    always @(posedge CPU_CLK) begin
        if (!RESET_N) cyc <= 0;
        else          cyc <= cyc + 1;
        rst_seen <= !RESET_N;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, mon_cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int   mc;            // model cycle
    int   busy_until;    // first cycle the sequencer is idle again
    int   next_exp;      // cycle in which the refresh interval expires
    bit   pending;       // refresh pending as seen in cycle mc
    int   clr_at;        // cycle from which a pending flag is cleared by REF
    bit   req_out;
    logic [31:0] req_addr;
    logic req_cmd;
    int   last_accept;

    function automatic void model_init();
        busy_until = T_INIT;
        next_exp   = T_INIT + T_REFI - 1;
        pending    = 1'b0;
        clr_at     = -1;
    endfunction

    function automatic void push_cmd(input int c, input logic [3:0] code, input logic [2:0] ba,
                                     input logic chk_ba, input logic [14:0] maddr,
                                     input logic rd, input logic wr);
        cmd_exp_t e;
        e.cyc = c; e.code = code; e.ba = ba; e.chk_ba = chk_ba;
        e.maddr = maddr; e.rd = rd; e.wr = wr;
        cmd_q.push_back(e);
    endfunction

    function automatic void model_cycle();
        bit idle;
        bit nxt;
        stat_exp_t s;
        idle = (mc >= busy_until);
        if (idle && pending) begin
            push_cmd(mc + 1, 4'b0001, 3'd0, 1'b0, 15'd0, 1'b0, 1'b0);
            busy_until = mc + 1 + T_RFC;
            clr_at     = mc + 2;
        end else if (idle && req_out) begin
            int a, rw, pre;
            logic [2:0]  ba;
            logic [14:0] row;
            logic [14:0] col;
            a   = mc + 1;
            rw  = a + T_RCD;
            pre = rw + (req_cmd ? T_WR2PRE : T_RD2PRE);
            if (a + T_RAS > pre) pre = a + T_RAS;
            ba  = 3'((req_addr >> 10) & 32'h7);
            row = 15'((req_addr >> 13) & 32'h7FFF);
            col = 15'(req_addr & 32'h3F8);
            push_cmd(a, 4'b0011, ba, 1'b1, row, 1'b0, 1'b0);
            push_cmd(rw, req_cmd ? 4'b0100 : 4'b0101, ba, 1'b1, col, !req_cmd, req_cmd);
            push_cmd(pre, 4'b0010, ba, 1'b1, 15'd0, 1'b0, 1'b0);
            busy_until  = pre + T_RP;
            req_out     = 1'b0;
            last_accept = mc;
        end
        if (mc == next_exp) begin
            nxt = 1'b1;
            next_exp += T_REFI;
        end else if (mc + 1 == clr_at) begin
            nxt = 1'b0;
        end else begin
            nxt = pending;
        end
        pending = nxt;
        s.cyc   = mc + 1;
        s.busy  = !(mc + 1 >= busy_until);
        s.rdy   = (mc + 1 >= busy_until) && !pending;
        s.quiet = (mc + 1 < T_INIT) ? 4'b1111 : 4'b0111;
        stat_q.push_back(s);
    endfunction

    // ---------------- stimulus ----------------
    task automatic step(input bit allow_new);
        @(negedge CPU_CLK);
        if (allow_new && !req_out && $urandom_range(0, 2) == 0) begin
            req_out  = 1'b1;
            req_addr = $urandom();
            req_cmd  = 1'($urandom_range(0, 1));
        end
        ADDR_VALID = req_out;
        ADDR       = req_out ? req_addr : $urandom();
        CMD        = req_out ? req_cmd : 1'($urandom_range(0, 1));
        model_cycle();
        mc++;
    endtask

    task automatic do_reset(input int n);
        @(negedge CPU_CLK);
        RESET_N    = 1'b0;
        ADDR_VALID = 1'b0;
        req_out    = 1'b0;
        cmd_q.delete();
        stat_q.delete();
        repeat (n) @(negedge CPU_CLK);
        RESET_N = 1'b1;
        model_init();
        mc = 0;
        model_cycle();
        mc = 1;
    endtask

    task automatic wait_accept(input int limit);
        int k = 0;
        while (req_out && k < limit) begin
            step(1'b0);
            k++;
        end
        if (req_out) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout @mc %0d: got pending request, expected accepted within %0d", mc, limit);
        end
    endtask

    task automatic run(input int n, input bit allow_new);
        for (int i = 0; i < n; i++) step(allow_new);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [3:0] pins;
        stat_exp_t  s;
        cmd_exp_t   e;
        forever begin
            @(posedge CPU_CLK);
            #2;
            mon_cyc = cyc;
            pins = {CS_N, RAS_N, CAS_N, WE_N};
            if (rst_seen) begin
                check("rst_pins", 32'(pins), 32'(4'b1111));
                check("rst_rdy", 32'(REQ_RDY), 32'd0);
                check("rst_busy", 32'(BUSY), 32'd1);
                check("rst_issue", 32'({RD_ISSUE, WR_ISSUE}), 32'd0);
                check("rst_ba", 32'(BA), 32'd0);
                check("rst_maddr", 32'(MADDR), 32'd0);
            end else if (stat_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL status_underflow @cyc %0d: got no expectation, expected one", cyc);
            end else begin
                s = stat_q.pop_front();
                check("status_align", 32'(cyc), 32'(s.cyc));
                check("req_rdy", 32'(REQ_RDY), 32'(s.rdy));
                check("busy", 32'(BUSY), 32'(s.busy));
                if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
                    e = cmd_q.pop_front();
                    check("cmd_pins", 32'(pins), 32'(e.code));
                    check("cmd_maddr", 32'(MADDR), 32'(e.maddr));
                    check("rd_issue", 32'(RD_ISSUE), 32'(e.rd));
                    check("wr_issue", 32'(WR_ISSUE), 32'(e.wr));
                    if (e.chk_ba) check("cmd_ba", 32'(BA), 32'(e.ba));
                    $display("cyc %0d cmd %b ba %0d maddr %h rd %0b wr %0b",
                             cyc, pins, BA, MADDR, RD_ISSUE, WR_ISSUE);
                end else begin
                    check("quiet_pins", 32'(pins), 32'(s.quiet));
                    check("quiet_issue", 32'({RD_ISSUE, WR_ISSUE}), 32'd0);
                    check("quiet_maddr", 32'(MADDR), 32'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of run, expected $finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        int e;
        req_out = 1'b0;
        model_init();
        mc = 0;
        do_reset(3);

        // Single read of the reference address: BA 3, row 1, col 0x048.
        req_out = 1'b1; req_addr = 32'h0000_2C48; req_cmd = 1'b0;
        wait_accept(T_INIT + 20);
        run(30, 1'b0);

        // Single write: PRE governed by the write-to-precharge time.
        req_out = 1'b1; req_addr = $urandom(); req_cmd = 1'b1;
        wait_accept(50);
        run(30, 1'b0);

        // Refresh priority: request raised when the pending flag becomes visible.
        e = next_exp;
        while (mc < e - 60) step(1'b1);
        while (mc < e + 1) step(1'b0);
        req_out = 1'b1; req_addr = $urandom(); req_cmd = 1'($urandom_range(0, 1));
        wait_accept(T_RFC + 20);

        // Refresh expiring while the access sits in WAIT_RCD.
        e = next_exp;
        while (mc < e - 60) step(1'b1);
        while (mc < e - 3) step(1'b0);
        req_out = 1'b1; req_addr = $urandom(); req_cmd = 1'($urandom_range(0, 1));
        wait_accept(10);
        run(300, 1'b1);

        // Reset during WAIT_PRE of a read.
        while (req_out) step(1'b0);
        run(60, 1'b0);
        req_out = 1'b1; req_addr = $urandom(); req_cmd = 1'b0;
        wait_accept(80);
        e = last_accept + 1 + T_RCD + 3;
        while (mc < e) step(1'b0);
        do_reset(3);

        run(T_INIT + 400, 1'b1);
        run(150, 1'b0);
        mon_cyc = cyc;
        check("cmdq_drained", 32'(cmd_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
